// File: rtl/ins_fetch.sv
// Instruction-fetch sequencer: drives PC to a combinational ROM and latches the returned word into IR.
// Optional halt-word detection is compiled in with `define HALT_DETECT_EN.
module ins_fetch #(
  parameter int                PC_W     = 4,
  parameter int                INS_W    = 11,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INS_W-1:0]  HALT_OP  = 11'b01100000000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STALL,
  input  logic             JMP,
  input  logic [PC_W-1:0]  JMP_ADDR,
  input  logic [INS_W-1:0] INS_IN,
  output logic [PC_W-1:0]  PC,
  output logic [INS_W-1:0] IR,
  output logic             IR_VALID,
  output logic             RUNNING,
  output logic             HALTED
);

`ifdef HALT_DETECT_EN
  localparam logic HALT_DETECT = 1'b1;
`else
  localparam logic HALT_DETECT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PC_W-1:0]  pc, pc_next;
  logic [INS_W-1:0] ir, ir_next;
  logic             ir_valid, ir_valid_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ir       <= ir_next;
      ir_valid <= ir_valid_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ir_next       = ir;
    ir_valid_next = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (START) begin
          state_next = FETCH;
          pc_next    = RESET_PC;
        end
      end
      FETCH: begin
        if (START) begin
          pc_next = RESET_PC;
        end else if (JMP) begin
          pc_next = JMP_ADDR;
        end else if (!STALL) begin
          ir_next       = INS_IN;
          ir_valid_next = 1'b1;
          // A halt word is still presented once on IR, but PC freezes on its address.
          if (HALT_DETECT && INS_IN == HALT_OP) begin
            state_next = HALT;
          end else begin
            pc_next = pc + PC_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = RESET_PC;
      end
    endcase
  end

  assign PC       = pc;
  assign IR       = ir;
  assign IR_VALID = ir_valid;
  assign RUNNING  = (state == FETCH);
  assign HALTED   = (state == HALT);

endmodule
